detector_linie_tura: RTL and testbench
======================================

// Module: detector_linie_tura
// PURPOSE
// Generates the one-cycle lap pulse consumed by the lap/BCD counter: watches the car's
// line sensors for the finish marker (transverse black stripe), debounces it, emits one
// pulse per crossing, then locks out so one stripe never counts twice. Sits between the
// sensor input pins and the lap counter's clock input.
// PARAMETERS
// NR_SENZORI    5           number of line sensors (bits of senzori)
// MIN_ACTIVE    5           sensors that must read black at once to form a marker; 1..NR_SENZORI
// DEBOUNCE_CYC  1000        consecutive marker cycles required before a pulse; >=1
// LOCKOUT_CYC   50_000_000  minimum cycles after a pulse before re-arming (1 s at 50 MHz); >=1
// PORTS
// tact          in   1           system clock; all logic on rising edge
// reset         in   1           synchronous, active-high reset
// enable        in   1           1 = detection active; 0 = force IDLE, no pulses
// senzori       in   NR_SENZORI  raw sensor bits, 1 = black under sensor; asynchronous
// tura_puls     out  1           registered, high exactly one cycle per accepted crossing
// marker_activ  out  1           synchronized marker condition (popcount >= MIN_ACTIVE)
// blocat        out  1           high while in LOCKOUT
// stare         out  2           FSM state: 00 IDLE, 01 CONFIRM, 10 PULSE, 11 LOCKOUT
// nr_respinse   out  8           count of aborted confirmations, saturates at 255
// BEHAVIOUR
// - Reset (reset=1 at edge): all outputs 0, state IDLE, counters 0, synchronizer flops 0.
// - senzori goes through a 2-flop synchronizer; marker = popcount(sync) >= MIN_ACTIVE.
// - IDLE: marker=1 -> CONFIRM, cnt<=1. Else stay.
// - CONFIRM: marker=0 -> IDLE, cnt<=0, nr_respinse+1 (hold at 255).
//   marker=1 and cnt==DEBOUNCE_CYC -> PULSE; else cnt<=cnt+1.
// - PULSE: one cycle; tura_puls=1 only here; -> LOCKOUT, cnt<=0 unconditionally.
// - LOCKOUT: cnt increments, saturating at LOCKOUT_CYC; exit to IDLE only when
//   cnt==LOCKOUT_CYC AND marker=0. Marker still present after timeout: stay (no re-count).
// - Latency: raw marker stable from edge 1 -> tura_puls high during cycle after edge
//   DEBOUNCE_CYC+3 (2 sync + DEBOUNCE_CYC confirm + 1 register).
// - enable=0 at any edge: next state IDLE, cnt<=0, tura_puls<=0; no nr_respinse increment.
//   enable has priority over all transitions; reset has priority over enable.
// - Reset mid-CONFIRM or mid-LOCKOUT: immediate return to IDLE, no pulse emitted.
// - Counter widths: $clog2(DEBOUNCE_CYC+1), $clog2(LOCKOUT_CYC+1); never wrap.
// - blocat = (stare==LOCKOUT); marker_activ = registered marker; outputs glitch-free.
// - MIN_ACTIVE<NR_SENZORI: any combination of >=MIN_ACTIVE sensors qualifies.
// TESTING (DEBOUNCE_CYC=4, LOCKOUT_CYC=20, NR_SENZORI=5, MIN_ACTIVE=5)
// - senzori=5'b11111 held from edge 1 -> tura_puls=1 for one cycle after edge 7, stare 10 then 11.
// - 11111 for 3 cycles then 00000 -> no pulse, nr_respinse=1, stare back to 00.
// - 11111 held 40 cycles -> exactly one pulse; blocat stays 1 until senzori=0 and 20 cycles done.
// - Two stripes 10 cycles apart (within lockout) -> one pulse; 30 cycles apart -> two pulses.
// - 5'b11110 held -> marker_activ=0, no pulse; 260 short glitches -> nr_respinse=255.
// - reset=1 during LOCKOUT / enable=0 during CONFIRM -> stare=00 next cycle, no pulse, outputs 0.

Source files
------------

// File: rtl/detector_linie_tura.sv
// Finish-line detector: synchronizes the line sensors, debounces the full-width stripe,
// emits one lap pulse per crossing and then locks out until the stripe has cleared.
module detector_linie_tura #(
  parameter int NR_SENZORI   = 5,
  parameter int MIN_ACTIVE   = 5,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int LOCKOUT_CYC  = 50_000_000
) (
  input  logic                  tact,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NR_SENZORI-1:0] senzori,
  output logic                  tura_puls,
  output logic                  marker_activ,
  output logic                  blocat,
  output logic [1:0]            stare,
  output logic [7:0]            nr_respinse
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONFIRM = 2'b01,
    PULSE   = 2'b10,
    LOCKOUT = 2'b11
  } stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [NR_SENZORI-1:0] sync1;
  logic                  markerNext;
  logic [DW-1:0]         cntDeb;
  logic [DW-1:0]         cntDebNext;
  logic [LW-1:0]         cntLock;
  logic [LW-1:0]         cntLockNext;
  logic [7:0]            respNext;

  function automatic logic isMarker(input logic [NR_SENZORI-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < NR_SENZORI; i++) begin
      if (v[i]) ones++;
    end
    return ones >= MIN_ACTIVE;
  endfunction

  // The popcount is taken on the first sync stage and registered, so marker_activ is
  // the second synchronizer stage and drives the FSM directly without extra latency.
  assign markerNext = isMarker(sync1);
  assign stare      = state;

  always_comb begin
    stateNext   = state;
    cntDebNext  = cntDeb;
    cntLockNext = cntLock;
    respNext    = nr_respinse;
    if (!enable) begin
      stateNext   = IDLE;
      cntDebNext  = '0;
      cntLockNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (marker_activ) begin
            stateNext  = CONFIRM;
            cntDebNext = DW'(1);
          end
        end
        CONFIRM: begin
          if (!marker_activ) begin
            stateNext  = IDLE;
            cntDebNext = '0;
            if (nr_respinse != 8'hFF) respNext = nr_respinse + 8'd1;
          end else if (cntDeb == DW'(DEBOUNCE_CYC)) begin
            stateNext = PULSE;
          end else begin
            cntDebNext = cntDeb + DW'(1);
          end
        end
        PULSE: begin
          stateNext   = LOCKOUT;
          cntDebNext  = '0;
          cntLockNext = '0;
        end
        LOCKOUT: begin
          // A stripe still under the car after the timeout keeps us here, never re-counted.
          if (cntLock == LW'(LOCKOUT_CYC)) begin
            if (!marker_activ) begin
              stateNext   = IDLE;
              cntLockNext = '0;
            end
          end else begin
            cntLockNext = cntLock + LW'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge tact) begin
    if (reset) begin
      sync1        <= '0;
      marker_activ <= 1'b0;
      state        <= IDLE;
      cntDeb       <= '0;
      cntLock      <= '0;
      nr_respinse  <= '0;
      tura_puls    <= 1'b0;
      blocat       <= 1'b0;
    end else begin
      sync1        <= senzori;
      marker_activ <= markerNext;
      state        <= stateNext;
      cntDeb       <= cntDebNext;
      cntLock      <= cntLockNext;
      nr_respinse  <= respNext;
      tura_puls    <= (stateNext == PULSE);
      blocat       <= (stateNext == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_detector_linie_tura.sv
// Directed bench for detector_linie_tura with short debounce/lockout so every path
// (latency, abort, lockout hold, spacing, saturation, reset/enable override) is reachable.
module tb_detector_linie_tura;

  logic       tact = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] senzori = 5'b0;
  logic       tura_puls;
  logic       marker_activ;
  logic       blocat;
  logic [1:0] stare;
  logic [7:0] nr_respinse;

  int errors = 0;
  int checks = 0;

  detector_linie_tura #(
    .NR_SENZORI(5),
    .MIN_ACTIVE(5),
    .DEBOUNCE_CYC(4),
    .LOCKOUT_CYC(20)
  ) dut (
    .tact(tact),
    .reset(reset),
    .enable(enable),
    .senzori(senzori),
    .tura_puls(tura_puls),
    .marker_activ(marker_activ),
    .blocat(blocat),
    .stare(stare),
    .nr_respinse(nr_respinse)
  );

  always #5 tact = ~tact;

  task automatic tick;
    @(posedge tact);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [4:0] s);
    enable  = en;
    senzori = s;
  endtask

  task automatic applyReset;
    reset = 1'b1;
    applyStimulus(1'b1, 5'b0);
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Drives a pattern for n edges and counts lap pulses seen after each edge.
  task automatic driveFor(input logic en, input logic [4:0] s, input int n, output int pulses);
    applyStimulus(en, s);
    pulses = 0;
    repeat (n) begin
      tick;
      if (tura_puls === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(1'b1, 5'b11111);
    tick;
    tick;
    checks++; if (tura_puls !== 1'b0) begin errors++; $display("[TB] FAIL reset_puls got=%b exp=0", tura_puls); end
    checks++; if (marker_activ !== 1'b0) begin errors++; $display("[TB] FAIL reset_marker got=%b exp=0", marker_activ); end
    checks++; if (blocat !== 1'b0) begin errors++; $display("[TB] FAIL reset_blocat got=%b exp=0", blocat); end
    checks++; if (stare !== 2'b00) begin errors++; $display("[TB] FAIL reset_stare got=%b exp=00", stare); end
    checks++; if (nr_respinse !== 8'd0) begin errors++; $display("[TB] FAIL reset_resp got=%0d exp=0", nr_respinse); end
    reset = 1'b0;
  endtask

  task automatic test_latency;
    logic [1:0] expState;
    logic       expPulse;
    logic       expMarker;
    applyReset;
    applyStimulus(1'b1, 5'b11111);
    for (int e = 1; e <= 8; e++) begin
      tick;
      expState  = (e <= 2) ? 2'b00 : (e <= 6) ? 2'b01 : (e == 7) ? 2'b10 : 2'b11;
      expPulse  = (e == 7);
      expMarker = (e >= 2);
      checks++; if (stare !== expState) begin errors++; $display("[TB] FAIL lat_stare e=%0d got=%b exp=%b", e, stare, expState); end
      checks++; if (tura_puls !== expPulse) begin errors++; $display("[TB] FAIL lat_puls e=%0d got=%b exp=%b", e, tura_puls, expPulse); end
      checks++; if (marker_activ !== expMarker) begin errors++; $display("[TB] FAIL lat_marker e=%0d got=%b exp=%b", e, marker_activ, expMarker); end
    end
    checks++; if (blocat !== 1'b1) begin errors++; $display("[TB] FAIL lat_blocat got=%b exp=1", blocat); end
  endtask

  task automatic test_abort;
    int p1, p2;
    applyReset;
    driveFor(1'b1, 5'b11111, 3, p1);
    driveFor(1'b1, 5'b00000, 10, p2);
    checks++; if (p1 + p2 != 0) begin errors++; $display("[TB] FAIL abort_pulses got=%0d exp=0", p1 + p2); end
    checks++; if (nr_respinse !== 8'd1) begin errors++; $display("[TB] FAIL abort_resp got=%0d exp=1", nr_respinse); end
    checks++; if (stare !== 2'b00) begin errors++; $display("[TB] FAIL abort_stare got=%b exp=00", stare); end
  endtask

  task automatic test_lockout_hold;
    int p1, p2, p3;
    applyReset;
    driveFor(1'b1, 5'b11111, 40, p1);
    checks++; if (p1 != 1) begin errors++; $display("[TB] FAIL hold_pulses got=%0d exp=1", p1); end
    checks++; if (blocat !== 1'b1) begin errors++; $display("[TB] FAIL hold_blocat40 got=%b exp=1", blocat); end
    driveFor(1'b1, 5'b00000, 2, p2);
    checks++; if (blocat !== 1'b1) begin errors++; $display("[TB] FAIL hold_blocat42 got=%b exp=1", blocat); end
    driveFor(1'b1, 5'b00000, 1, p3);
    checks++; if (blocat !== 1'b0) begin errors++; $display("[TB] FAIL hold_blocat43 got=%b exp=0", blocat); end
    checks++; if (stare !== 2'b00) begin errors++; $display("[TB] FAIL hold_stare got=%b exp=00", stare); end
    checks++; if (p2 + p3 != 0) begin errors++; $display("[TB] FAIL hold_extra got=%0d exp=0", p2 + p3); end
  endtask

  task automatic test_back_to_back;
    int a, b, c, d;
    applyReset;
    driveFor(1'b1, 5'b11111, 8, a);
    driveFor(1'b1, 5'b00000, 10, b);
    driveFor(1'b1, 5'b11111, 8, c);
    driveFor(1'b1, 5'b00000, 20, d);
    checks++; if (a + b + c + d != 1) begin errors++; $display("[TB] FAIL near_pulses got=%0d exp=1", a + b + c + d); end
    checks++; if (stare !== 2'b00) begin errors++; $display("[TB] FAIL near_stare got=%b exp=00", stare); end
    applyReset;
    driveFor(1'b1, 5'b11111, 8, a);
    driveFor(1'b1, 5'b00000, 30, b);
    driveFor(1'b1, 5'b11111, 8, c);
    driveFor(1'b1, 5'b00000, 20, d);
    checks++; if (a + b + c + d != 2) begin errors++; $display("[TB] FAIL far_pulses got=%0d exp=2", a + b + c + d); end
    checks++; if (c != 1) begin errors++; $display("[TB] FAIL far_second got=%0d exp=1", c); end
  endtask

  task automatic test_partial_and_saturation;
    int p, q, total;
    applyReset;
    driveFor(1'b1, 5'b11110, 20, p);
    checks++; if (marker_activ !== 1'b0) begin errors++; $display("[TB] FAIL part_marker got=%b exp=0", marker_activ); end
    checks++; if (p != 0) begin errors++; $display("[TB] FAIL part_pulses got=%0d exp=0", p); end
    total = 0;
    for (int g = 1; g <= 260; g++) begin
      driveFor(1'b1, 5'b11111, 1, p);
      driveFor(1'b1, 5'b00000, 4, q);
      total += p + q;
      if (g == 254) begin
        checks++; if (nr_respinse !== 8'd254) begin errors++; $display("[TB] FAIL sat_254 got=%0d exp=254", nr_respinse); end
      end
    end
    checks++; if (nr_respinse !== 8'd255) begin errors++; $display("[TB] FAIL sat_255 got=%0d exp=255", nr_respinse); end
    checks++; if (total != 0) begin errors++; $display("[TB] FAIL sat_pulses got=%0d exp=0", total); end
  endtask

  task automatic test_reset_lockout;
    int p;
    applyReset;
    driveFor(1'b1, 5'b11111, 10, p);
    checks++; if (stare !== 2'b11) begin errors++; $display("[TB] FAIL rstlk_pre got=%b exp=11", stare); end
    reset = 1'b1;
    tick;
    checks++; if (stare !== 2'b00) begin errors++; $display("[TB] FAIL rstlk_stare got=%b exp=00", stare); end
    checks++; if (blocat !== 1'b0) begin errors++; $display("[TB] FAIL rstlk_blocat got=%b exp=0", blocat); end
    checks++; if (marker_activ !== 1'b0) begin errors++; $display("[TB] FAIL rstlk_marker got=%b exp=0", marker_activ); end
    checks++; if (tura_puls !== 1'b0) begin errors++; $display("[TB] FAIL rstlk_puls got=%b exp=0", tura_puls); end
    reset = 1'b0;
    driveFor(1'b1, 5'b00000, 5, p);
    checks++; if (p != 0) begin errors++; $display("[TB] FAIL rstlk_after got=%0d exp=0", p); end
  endtask

  task automatic test_enable_confirm;
    int p;
    applyReset;
    driveFor(1'b1, 5'b11111, 4, p);
    checks++; if (stare !== 2'b01) begin errors++; $display("[TB] FAIL en_pre got=%b exp=01", stare); end
    driveFor(1'b0, 5'b11111, 1, p);
    checks++; if (stare !== 2'b00) begin errors++; $display("[TB] FAIL en_stare got=%b exp=00", stare); end
    checks++; if (tura_puls !== 1'b0) begin errors++; $display("[TB] FAIL en_puls got=%b exp=0", tura_puls); end
    driveFor(1'b0, 5'b11111, 3, p);
    checks++; if (p != 0) begin errors++; $display("[TB] FAIL en_hold_pulses got=%0d exp=0", p); end
    checks++; if (nr_respinse !== 8'd0) begin errors++; $display("[TB] FAIL en_resp got=%0d exp=0", nr_respinse); end
    driveFor(1'b1, 5'b11111, 4, p);
    checks++; if (p != 0 || stare !== 2'b01) begin errors++; $display("[TB] FAIL en_rearm got=%0d/%b exp=0/01", p, stare); end
    tick;
    checks++; if (tura_puls !== 1'b1) begin errors++; $display("[TB] FAIL en_pulse got=%b exp=1", tura_puls); end
    checks++; if (stare !== 2'b10) begin errors++; $display("[TB] FAIL en_pstare got=%b exp=10", stare); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_abort;
    test_lockout_hold;
    test_back_to_back;
    test_partial_and_saturation;
    test_reset_lockout;
    test_enable_confirm;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
